pc_sequencer: RTL

//  Owns the program counter and sequences instruction fetch for the MP3 CPU.

---
 rtl/pc_sequencer.sv | 85 ++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches over a req/ready handshake, holds the instruction for execute
// and picks the next PC (sequential, relative branch or register jump); faults are sticky until reset.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        instr_accept,
    input  logic        br_taken,
    input  logic [31:0] br_imm,
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    output logic        fault
);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

    state_t          state, state_d;
    logic [31:0]     pc, pc_d, instr_d, pc_out_d;
    logic [WW-1:0]   wait_cnt, wait_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            instr    <= '0;
            pc_out   <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            instr    <= instr_d;
            pc_out   <= pc_out_d;
            wait_cnt <= wait_d;
        end
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        instr_d  = instr;
        pc_out_d = pc_out;
        wait_d   = wait_cnt;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc;
                    wait_d   = '0;
                    state_d  = HOLD;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                    if (MAX_WAIT != 0 && wait_d == WW'(MAX_WAIT))
                        state_d = FAULT;
                end
            end
            HOLD: begin
                if (instr_accept) begin
                    state_d = FETCH;
                    // a misaligned jump faults without touching the PC
                    if (jr_en)
                        if (jr_addr[1:0] != 2'b00) state_d = FAULT;
                        else pc_d = jr_addr;
                    else
                        pc_d = pc + 32'd4 + (br_taken ? {br_imm[29:0], 2'b00} : 32'd0);
                end
            end
            default: ;
        endcase
    end

    assign imem_req    = state == FETCH;
    assign imem_addr   = pc;
    assign instr_valid = state == HOLD;
    assign fault       = state == FAULT;
endmodule
